// File: rtl/normshift_seq.sv
// Multi-cycle normalization shifter: coarse STEP-bit left shifts one per cycle, then a
// single fine shift, clamped so the total shift never exceeds the caller-supplied limit.
module normshift_seq #(
  parameter int W    = 128,
  parameter int NE   = 11,
  parameter int STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Flush,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [W-1:0]         X,
  input  logic [NE+1:0]        ExpIn,
  input  logic [$clog2(W)-1:0] Limit,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [W-1:0]         Shifted,
  output logic [$clog2(W)-1:0] ShiftAmt,
  output logic [NE+1:0]        NormExp,
  output logic                 ZeroRes,
  output logic                 LimitHit
);
  localparam int AW = $clog2(W);
  localparam int LW = $clog2(STEP) + 1;

  typedef enum logic [1:0] {IDLE, COARSE, DONE} state_t;

  state_t          state_reg;
  logic [W-1:0]    s_reg;
  logic [AW-1:0]   cnt_reg;
  logic [NE+1:0]   e_reg;
  logic [AW-1:0]   l_reg;
  logic [AW-1:0]   rem_reg;

  logic [STEP-1:0] top_bits;
  logic [LW-1:0]   top_lz;
  logic [AW-1:0]   top_lz_ext;
  logic [AW-1:0]   fine_amt;
  logic            coarse_ok;

  assign top_bits = s_reg[W-1 -: STEP];

  // Leading-zero count of the top window; an all-zero window counts as STEP.
  always_comb begin
    top_lz = LW'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (top_bits[i]) top_lz = LW'(STEP - 1 - i);
    end
  end

  assign top_lz_ext = AW'(top_lz);
  assign fine_amt   = (top_lz_ext < rem_reg) ? top_lz_ext : rem_reg;
  assign coarse_ok  = (top_bits == '0) && (rem_reg >= AW'(STEP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      cnt_reg   <= '0;
      e_reg     <= '0;
      l_reg     <= '0;
      rem_reg   <= '0;
    end else if (Flush) begin
      // Abort keeps the datapath registers; only the handshake state is cleared.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (InValid) begin
            s_reg     <= X;
            e_reg     <= ExpIn;
            l_reg     <= Limit;
            rem_reg   <= Limit;
            cnt_reg   <= '0;
            state_reg <= COARSE;
          end
        end
        COARSE: begin
          if (coarse_ok) begin
            s_reg   <= s_reg << STEP;
            cnt_reg <= cnt_reg + AW'(STEP);
            rem_reg <= rem_reg - AW'(STEP);
          end else begin
            s_reg     <= s_reg << fine_amt;
            cnt_reg   <= cnt_reg + fine_amt;
            rem_reg   <= rem_reg - fine_amt;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (OutReady) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign InReady  = (state_reg == IDLE);
  assign OutValid = (state_reg == DONE);
  assign Shifted  = s_reg;
  assign ShiftAmt = cnt_reg;
  // Exponent wraps modulo 2^(NE+2); range checking belongs to the consumer.
  assign NormExp  = e_reg - (NE+2)'(cnt_reg);
  assign ZeroRes  = (s_reg == '0);
  assign LimitHit = (cnt_reg == l_reg) && !s_reg[W-1];

endmodule

// File: tb/tb_normshift_seq.sv
// Self-checking bench for normshift_seq: directed cases, random operations against a
// leading-zero/clamp reference model, back-to-back throughput, flush and async reset.
module tb_normshift_seq;
  localparam int W = 128, NE = 11, STEP = 8, AW = 7;

  logic          clk = 1'b0, reset_n = 1'b0, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic          InReady, OutValid, ZeroRes, LimitHit;
  logic [W-1:0]  X = '0, Shifted;
  logic [NE+1:0] ExpIn = '0, NormExp;
  logic [AW-1:0] Limit = '0, ShiftAmt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  normshift_seq #(.W(W), .NE(NE), .STEP(STEP)) dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .X(X), .ExpIn(ExpIn), .Limit(Limit), .OutValid(OutValid), .OutReady(OutReady),
    .Shifted(Shifted), .ShiftAmt(ShiftAmt), .NormExp(NormExp), .ZeroRes(ZeroRes),
    .LimitHit(LimitHit)
  );

  typedef struct {
    logic [W-1:0]  sh;
    logic [AW-1:0] amt;
    logic [NE+1:0] ne;
    logic          z;
    logic          lh;
    int            lat;
  } exp_t;

  // Reference: total shift is min(leading zeros, limit); OutValid seen after
  // S/STEP+2 edges, counting the accepting edge as the first.
  function automatic exp_t model(input logic [W-1:0] x, input logic [NE+1:0] e,
                                 input logic [AW-1:0] lim);
    exp_t m;
    int lz = W;
    int s;
    for (int i = 0; i < W; i++) if (x[i]) lz = W - 1 - i;
    s = (lz < int'(lim)) ? lz : int'(lim);
    m.sh  = x << s;
    m.amt = AW'(s);
    m.ne  = e - (NE+2)'(s);
    m.z   = (m.sh == '0);
    m.lh  = (s == int'(lim)) && !m.sh[W-1];
    m.lat = s / STEP + 2;
    return m;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [NE+1:0] e,
                       input logic [AW-1:0] lim, output int lat);
    X = x; ExpIn = e; Limit = lim; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; X = rand_wide(); ExpIn = (NE+2)'($urandom); Limit = AW'($urandom);
    lat = 1;
    while (OutValid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b want=1", InReady); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b want=0", OutValid); end
    checks++; if (Shifted !== '0 || ShiftAmt !== '0 || NormExp !== '0) begin failures++;
      $display("FAIL reset_regs shifted=%h amt=%0d exp=%0d want 0", Shifted, ShiftAmt, NormExp); end
    checks++; if (ZeroRes !== 1'b1 || LimitHit !== 1'b1) begin failures++;
      $display("FAIL reset_flags zero=%b limhit=%b want 1 1", ZeroRes, LimitHit); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("txn reset released");
  endtask

  task automatic test_directed();
    logic [W-1:0]  d_x [4];
    logic [NE+1:0] d_e [4];
    logic [AW-1:0] d_l [4], d_amt [4];
    logic [W-1:0]  d_sh [4];
    logic [NE+1:0] d_ne [4];
    logic          d_z [4], d_lh [4];
    int            d_lat [4];
    int            lat;
    logic [W-1:0]  one = 1;
    d_x[0] = one << 100; d_e[0] = 50; d_l[0] = 127; d_amt[0] = 27;  d_sh[0] = one << 127;
    d_ne[0] = 23;   d_z[0] = 0; d_lh[0] = 0; d_lat[0] = 5;
    d_x[1] = one;        d_e[1] = 0;  d_l[1] = 5;   d_amt[1] = 5;   d_sh[1] = one << 5;
    d_ne[1] = 8187; d_z[1] = 0; d_lh[1] = 1; d_lat[1] = 2;
    d_x[2] = '0;         d_e[2] = 0;  d_l[2] = 127; d_amt[2] = 127; d_sh[2] = '0;
    d_ne[2] = 8065; d_z[2] = 1; d_lh[2] = 1; d_lat[2] = 17;
    d_x[3] = (one << 127) | (rand_wide() >> 1); d_e[3] = 0; d_l[3] = 77; d_amt[3] = 0;
    d_sh[3] = d_x[3]; d_ne[3] = 0; d_z[3] = 0; d_lh[3] = 0; d_lat[3] = 2;
    for (int k = 0; k < 4; k++) begin
      do_op(d_x[k], d_e[k], d_l[k], lat);
      $display("txn directed%0d lim=%0d amt=%0d exp=%0d lat=%0d", k + 1, d_l[k], ShiftAmt, NormExp, lat);
      checks++; if (lat != d_lat[k]) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", k + 1, lat, d_lat[k]); end
      checks++; if (ShiftAmt !== d_amt[k]) begin failures++; $display("FAIL dir%0d_shiftamt got=%0d want=%0d", k + 1, ShiftAmt, d_amt[k]); end
      checks++; if (Shifted !== d_sh[k]) begin failures++; $display("FAIL dir%0d_shifted got=%h want=%h", k + 1, Shifted, d_sh[k]); end
      checks++; if (NormExp !== d_ne[k]) begin failures++; $display("FAIL dir%0d_normexp got=%0d want=%0d", k + 1, NormExp, d_ne[k]); end
      checks++; if (ZeroRes !== d_z[k] || LimitHit !== d_lh[k]) begin failures++;
        $display("FAIL dir%0d_flags zero=%b limhit=%b want %b %b", k + 1, ZeroRes, LimitHit, d_z[k], d_lh[k]); end
      release_out();
    end
  endtask

  task automatic test_hold();
    exp_t m;
    int lat;
    logic [W-1:0] x = rand_wide() >> 37;
    m = model(x, 13'd900, 7'd127);
    do_op(x, 13'd900, 7'd127, lat);
    checks++; if (lat != m.lat) begin failures++; $display("FAIL hold_latency got=%0d want=%0d", lat, m.lat); end
    for (int c = 0; c < 10; c++) begin
      InValid = 1'b1; X = rand_wide(); Limit = AW'($urandom);
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || InReady !== 1'b0 || Shifted !== m.sh || ShiftAmt !== m.amt || NormExp !== m.ne) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d valid=%b ready=%b amt=%0d exp=%0d want amt=%0d exp=%0d",
                 c, OutValid, InReady, ShiftAmt, NormExp, m.amt, m.ne);
      end
    end
    InValid = 1'b0;
    release_out();
    $display("txn hold amt=%0d ready=%b valid=%b", ShiftAmt, InReady, OutValid);
    checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin failures++;
      $display("FAIL hold_release ready=%b valid=%b want 1 0", InReady, OutValid); end
  endtask

  task automatic test_random();
    exp_t m;
    int lat;
    logic [W-1:0]  x;
    logic [NE+1:0] e;
    logic [AW-1:0] lim;
    int sel;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      x   = (sel == 0) ? '0 : (rand_wide() >> $urandom_range(0, 127));
      e   = (NE+2)'($urandom);
      lim = (sel == 1) ? '0 : AW'($urandom);
      m = model(x, e, lim);
      do_op(x, e, lim, lat);
      $display("txn rand%0d lim=%0d amt=%0d exp=%0d lat=%0d", n, lim, ShiftAmt, NormExp, lat);
      checks++;
      if (lat != m.lat || ShiftAmt !== m.amt || Shifted !== m.sh || NormExp !== m.ne ||
          ZeroRes !== m.z || LimitHit !== m.lh) begin
        failures++;
        $display("FAIL rand%0d lat=%0d amt=%0d exp=%0d z=%b lh=%b want lat=%0d amt=%0d exp=%0d z=%b lh=%b",
                 n, lat, ShiftAmt, NormExp, ZeroRes, LimitHit, m.lat, m.amt, m.ne, m.z, m.lh);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t m;
    logic [W-1:0] x;
    int issued = 0, done = 0, edge_n = 0, prev_done = -1;
    OutReady = 1'b1;
    while (done < 6 && edge_n < 400) begin
      if (OutValid === 1'b1) begin
        if (q.size() == 0) begin
          checks++; failures++; $display("FAIL b2b_spurious got=valid want=none");
        end else begin
          m = q.pop_front();
          $display("txn b2b%0d amt=%0d edge=%0d", done, ShiftAmt, edge_n);
          checks++;
          if (ShiftAmt !== m.amt || Shifted !== m.sh || NormExp !== m.ne) begin failures++;
            $display("FAIL b2b_result amt=%0d exp=%0d want amt=%0d exp=%0d", ShiftAmt, NormExp, m.amt, m.ne); end
          if (prev_done >= 0) begin
            checks++;
            if (edge_n - prev_done != m.lat + 1) begin failures++;
              $display("FAIL b2b_period got=%0d want=%0d", edge_n - prev_done, m.lat + 1); end
          end
          prev_done = edge_n;
          done++;
        end
      end
      if (issued < 6) begin
        InValid = 1'b1;
        if (InReady === 1'b1) begin
          x = rand_wide() >> $urandom_range(0, 40);
          X = x; ExpIn = 13'd100; Limit = 7'd127;
          q.push_back(model(x, 13'd100, 7'd127));
          issued++;
        end else begin
          X = rand_wide();
        end
      end else begin
        InValid = 1'b0;
      end
      @(posedge clk); #1;
      edge_n++;
    end
    InValid = 1'b0;
    OutReady = 1'b0;
    checks++; if (done != 6) begin failures++; $display("FAIL b2b_timeout got=%0d want=6", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int seen = 0;
    X = 128'd1 << 100; ExpIn = 13'd50; Limit = 7'd127; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    @(posedge clk); #1;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    $display("txn flush ready=%b valid=%b amt=%0d", InReady, OutValid, ShiftAmt);
    checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin failures++;
      $display("FAIL flush_state ready=%b valid=%b want 1 0", InReady, OutValid); end
    checks++; if (ShiftAmt !== 7'd8) begin failures++; $display("FAIL flush_hold amt=%0d want=8", ShiftAmt); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (OutValid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flush_novalid got=%0d want=0", seen); end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    X = 128'd1 << 100; ExpIn = 13'd50; Limit = 7'd127; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    $display("txn reset_midop ready=%b valid=%b amt=%0d", InReady, OutValid, ShiftAmt);
    checks++; if (InReady !== 1'b1 || OutValid !== 1'b0) begin failures++;
      $display("FAIL rstmid_state ready=%b valid=%b want 1 0", InReady, OutValid); end
    checks++; if (ShiftAmt !== '0 || Shifted !== '0 || ZeroRes !== 1'b1 || LimitHit !== 1'b1) begin failures++;
      $display("FAIL rstmid_regs amt=%0d zero=%b limhit=%b want 0 1 1", ShiftAmt, ZeroRes, LimitHit); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (OutValid === 1'b1 || InReady !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rstmid_idle bad_cycles=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
